// File: rtl/ias_pkg.sv
// Shared definitions for the IAS instruction sequencer: opcode values, FSM
// state encoding and small opcode-classification helpers.
package ias_pkg;

  // Opcode values; only the low three bits are meaningful, upper bits must be zero.
  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_LOAD     = 3'd1;
  localparam logic [2:0] OP_STORE    = 3'd2;
  localparam logic [2:0] OP_ADD      = 3'd3;
  localparam logic [2:0] OP_SUB      = 3'd4;
  localparam logic [2:0] OP_LOAD_MQ  = 3'd5;
  localparam logic [2:0] OP_STORE_AC = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StMemRd,
    StExecute,
    StWriteBack,
    StDone
  } state_e;

  // Opcodes that fetch a memory operand before executing.
  function automatic logic is_read_op(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOAD_MQ);
  endfunction

  // Opcodes that write memory.
  function automatic logic is_write_op(input logic [2:0] op);
    return (op == OP_STORE) || (op == OP_STORE_AC);
  endfunction

endpackage

// File: rtl/ias_wait_timer.sv
// 3-bit down-counter used to hold the sequencer in the memory-read state for
// the configured read latency. Expired is high while the count is zero.
module ias_wait_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic       en_i,
  output logic       expired_o
);

  logic [2:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == 3'd0);

endmodule

// File: rtl/ias_instr_sequencer.sv
// Control sequencer for the IAS datapath. Accepts one command per valid/ready
// handshake, walks it through decode, memory read wait, execute and write-back,
// and drives memory strobes and AC/MQ enables as Moore outputs of the state.
module ias_instr_sequencer
  import ias_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned OPC_W      = 8,
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] ac_data,
  output logic [DATA_W-1:0] operand,
  output logic              load_ac,
  output logic              add_enable,
  output logic              sub_enable,
  output logic              load_mq,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired_cnt
);

  // Timer reload value: the last read cycle is the one where the count hits zero.
  localparam logic [2:0] RdWaitLoad = 3'(MEM_RD_LAT - 1);

  state_e            state_q, state_d;
  logic [OPC_W-1:0]  ir_q;
  logic [ADDR_W-1:0] ar_q;
  logic [DATA_W-1:0] dr_q;
  logic [DATA_W-1:0] operand_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [2:0] op;
  logic       op_legal;
  logic       accept;
  logic       rd_expired;

  assign op       = ir_q[2:0];
  // Upper opcode bits must be zero and code 7 is undefined.
  assign op_legal = ((ir_q >> 3) == '0) && (op != 3'd7);
  assign accept   = (state_q == StIdle) && cmd_valid;

  ias_wait_timer u_wait_timer (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (state_q == StDecode),
    .load_val_i (RdWaitLoad),
    .en_i       (state_q == StMemRd),
    .expired_o  (rd_expired)
  );

  // Next-state and Moore output decode.
  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = '0;
    load_ac    = 1'b0;
    add_enable = 1'b0;
    sub_enable = 1'b0;
    load_mq    = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!op_legal) begin
          state_d = StDone;
        end else if (is_read_op(op)) begin
          state_d = StMemRd;
        end else if (is_write_op(op)) begin
          state_d = StWriteBack;
        end else begin
          state_d = StDone;
        end
      end
      StMemRd: begin
        mem_read = 1'b1;
        if (rd_expired) begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        load_ac    = (op == OP_LOAD);
        add_enable = (op == OP_ADD);
        sub_enable = (op == OP_SUB);
        load_mq    = (op == OP_LOAD_MQ);
        state_d    = StDone;
      end
      StWriteBack: begin
        mem_write = 1'b1;
        // STORE_AC takes the live AC value seen during this cycle.
        mem_wdata = (op == OP_STORE_AC) ? ac_data : dr_q;
        state_d   = StDone;
      end
      StDone: begin
        done    = 1'b1;
        illegal = !op_legal;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latches (IR/AR/DR), loaded only on the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q <= '0;
      ar_q <= '0;
      dr_q <= '0;
    end else if (accept) begin
      ir_q <= opcode;
      ar_q <= address;
      dr_q <= data_in;
    end
  end

  // Operand capture on the final memory-read edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      operand_q <= '0;
    end else if ((state_q == StMemRd) && rd_expired) begin
      operand_q <= mem_rdata;
    end
  end

  // Retired-instruction counter, one step per done pulse, free-running wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == StDone) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign busy        = (state_q != StIdle);
  assign mem_addr    = ar_q;
  assign operand     = operand_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_ias_instr_sequencer.sv
// Bench for ias_instr_sequencer: emulates memory and AC/MQ around the DUT,
// runs a table of directed commands, random commands against a reference
// model, a mid-command reset and a held-valid sequence.
module tb_ias_instr_sequencer;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  opcode;
  logic [7:0]  address;
  logic [7:0]  data_in;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic [7:0]  ac_data;
  logic [7:0]  operand;
  logic        load_ac;
  logic        add_enable;
  logic        sub_enable;
  logic        load_mq;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [15:0] retired_cnt;

  always #5 clk = ~clk;

  ias_instr_sequencer #(
    .DATA_W     (8),
    .ADDR_W     (8),
    .OPC_W      (8),
    .MEM_RD_LAT (LAT),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .opcode      (opcode),
    .address     (address),
    .data_in     (data_in),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_rdata   (mem_rdata),
    .ac_data     (ac_data),
    .operand     (operand),
    .load_ac     (load_ac),
    .add_enable  (add_enable),
    .sub_enable  (sub_enable),
    .load_mq     (load_mq),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .retired_cnt (retired_cnt)
  );

  // Emulated datapath: memory, AC, MQ.
  logic [7:0]  mem [256] = '{default: 8'd0};
  logic [7:0]  ac = 8'd0;
  logic [7:0]  mq = 8'd0;
  int unsigned rd_run = 0;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (load_ac) ac <= operand;
    if (add_enable) ac <= ac + operand;
    if (sub_enable) ac <= ac - operand;
    if (load_mq) mq <= operand;
    rd_run <= mem_read ? rd_run + 1 : 0;
  end

  assign ac_data = ac;
  // Read data only becomes valid in the LAT-th consecutive read cycle.
  assign mem_rdata = (mem_read && (rd_run >= LAT - 1)) ? mem[mem_addr] : 8'hA5;

  // Reference model state.
  logic [7:0]  ref_mem [256] = '{default: 8'd0};
  logic [7:0]  ref_ac = 8'd0;
  logic [7:0]  ref_mq = 8'd0;
  logic [15:0] ref_cnt = 16'd0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  typedef struct {
    int         lat;
    int         n_rd;
    int         n_wr;
    int         n_ld;
    int         n_add;
    int         n_sub;
    int         n_mq;
    int         glitch;
    logic       ill;
    logic [7:0] opnd;
    logic [7:0] wdata;
    logic [7:0] addr_seen;
  } res_t;

  // Present one command, observe every cycle up to done, return in IDLE.
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                         output res_t r);
    int g;
    r = '{default: 0};
    cmd_valid = 1'b1;
    opcode    = op;
    address   = a;
    data_in   = d;
    g = 0;
    while (!cmd_ready && g < 30) begin
      @(posedge clk); #1;
      g++;
    end
    if (!cmd_ready) begin
      fail_now("ready_wait");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    opcode    = 8'($urandom);
    address   = 8'($urandom);
    data_in   = 8'($urandom);
    r.lat = 1;
    while (1) begin
      if (mem_read) begin r.n_rd++; r.addr_seen = mem_addr; end
      if (mem_write) begin r.n_wr++; r.wdata = mem_wdata; r.addr_seen = mem_addr; end
      if (mem_read && mem_write) r.glitch++;
      if (illegal && !done) r.glitch++;
      if (cmd_ready && busy) r.glitch++;
      if (load_ac) begin r.n_ld++; r.opnd = operand; end
      if (add_enable) begin r.n_add++; r.opnd = operand; end
      if (sub_enable) begin r.n_sub++; r.opnd = operand; end
      if (load_mq) begin r.n_mq++; r.opnd = operand; end
      if (done) begin
        r.ill = illegal;
        break;
      end
      if (r.lat >= 40) begin
        fail_now("done_wait");
        break;
      end
      @(posedge clk); #1;
      r.lat++;
    end
    @(posedge clk); #1;
  endtask

  // Run a command and check it against the reference model.
  task automatic do_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                        output res_t r);
    bit         legal, rd, wr;
    int         exp_lat;
    logic [7:0] exp_opnd, exp_wdata;
    legal     = (op <= 8'd6);
    rd        = legal && (op inside {8'd1, 8'd3, 8'd4, 8'd5});
    wr        = legal && (op inside {8'd2, 8'd6});
    exp_lat   = rd ? 3 + int'(LAT) : (wr ? 3 : 2);
    exp_opnd  = ref_mem[a];
    exp_wdata = (op == 8'd2) ? d : ref_ac;
    run_cmd(op, a, d, r);
    chk("latency", 32'(r.lat), 32'(exp_lat));
    chk("read_cycles", 32'(r.n_rd), rd ? 32'(LAT) : 32'd0);
    chk("write_cycles", 32'(r.n_wr), wr ? 32'd1 : 32'd0);
    chk("load_ac_cnt", 32'(r.n_ld), 32'(legal && op == 8'd1));
    chk("add_cnt", 32'(r.n_add), 32'(legal && op == 8'd3));
    chk("sub_cnt", 32'(r.n_sub), 32'(legal && op == 8'd4));
    chk("load_mq_cnt", 32'(r.n_mq), 32'(legal && op == 8'd5));
    chk("illegal_flag", 32'(r.ill), 32'(!legal));
    chk("strobe_glitch", 32'(r.glitch), 32'd0);
    if (rd) begin
      chk("operand", 32'(r.opnd), 32'(exp_opnd));
      chk("read_addr", 32'(r.addr_seen), 32'(a));
    end
    if (wr) begin
      chk("wdata", 32'(r.wdata), 32'(exp_wdata));
      chk("write_addr", 32'(r.addr_seen), 32'(a));
    end
    if (legal) begin
      case (op)
        8'd1: ref_ac = exp_opnd;
        8'd2: ref_mem[a] = d;
        8'd3: ref_ac = ref_ac + exp_opnd;
        8'd4: ref_ac = ref_ac - exp_opnd;
        8'd5: ref_mq = exp_opnd;
        8'd6: ref_mem[a] = ref_ac;
        default: ;
      endcase
    end
    ref_cnt = ref_cnt + 16'd1;
    chk("ac_value", 32'(ac), 32'(ref_ac));
    chk("mq_value", 32'(mq), 32'(ref_mq));
    if (wr) chk("mem_value", 32'(mem[a]), 32'(ref_mem[a]));
    chk("retired_cnt", 32'(retired_cnt), 32'(ref_cnt));
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("ready_after", 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  a;
    logic [7:0]  d;
    int          exp_lat;
    logic [7:0]  exp_val;
    logic [7:0]  exp_ac;
    logic        exp_ill;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [12];

  initial begin
    res_t r;
    logic [7:0] ac_before;
    int acc, dn, exp_acc, exp_dn, period, g;

    vecs[0]  = '{8'd2,    8'd1, 8'd25,  3, 8'd25,  8'd0,   1'b0, 16'd1};
    vecs[1]  = '{8'd2,    8'd2, 8'd50,  3, 8'd50,  8'd0,   1'b0, 16'd2};
    vecs[2]  = '{8'd1,    8'd1, 8'd0,   6, 8'd25,  8'd25,  1'b0, 16'd3};
    vecs[3]  = '{8'd3,    8'd2, 8'd0,   6, 8'd50,  8'd75,  1'b0, 16'd4};
    vecs[4]  = '{8'd6,    8'd3, 8'd0,   3, 8'd75,  8'd75,  1'b0, 16'd5};
    vecs[5]  = '{8'd4,    8'd2, 8'd0,   6, 8'd50,  8'd25,  1'b0, 16'd6};
    vecs[6]  = '{8'd9,    8'd1, 8'd0,   2, 8'd0,   8'd25,  1'b1, 16'd7};
    vecs[7]  = '{8'h81,   8'd1, 8'd0,   2, 8'd0,   8'd25,  1'b1, 16'd8};
    vecs[8]  = '{8'd0,    8'd1, 8'd0,   2, 8'd0,   8'd25,  1'b0, 16'd9};
    vecs[9]  = '{8'd5,    8'd3, 8'd0,   6, 8'd75,  8'd25,  1'b0, 16'd10};
    vecs[10] = '{8'd2,    8'd4, 8'd150, 3, 8'd150, 8'd25,  1'b0, 16'd11};
    vecs[11] = '{8'd1,    8'd4, 8'd0,   6, 8'd150, 8'd150, 1'b0, 16'd12};

    reset     = 1'b0;
    cmd_valid = 1'b0;
    opcode    = 8'd0;
    address   = 8'd0;
    data_in   = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes", 32'({mem_read, mem_write, load_ac, add_enable, sub_enable, load_mq,
                              busy, done, illegal}), 32'd0);
    chk("reset_regs", 32'({operand, mem_addr, mem_wdata}), 32'd0);
    chk("reset_cnt", 32'(retired_cnt), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      do_cmd(vecs[i].op, vecs[i].a, vecs[i].d, r);
      chk("tbl_latency", 32'(r.lat), 32'(vecs[i].exp_lat));
      chk("tbl_value", 32'(r.n_wr > 0 ? r.wdata : r.opnd), 32'(vecs[i].exp_val));
      chk("tbl_ac", 32'(ac), 32'(vecs[i].exp_ac));
      chk("tbl_illegal", 32'(r.ill), 32'(vecs[i].exp_ill));
      chk("tbl_cnt", 32'(retired_cnt), 32'(vecs[i].exp_cnt));
    end
    chk("mem1", 32'(mem[1]), 32'd25);
    chk("mem2", 32'(mem[2]), 32'd50);
    chk("mem3", 32'(mem[3]), 32'd75);

    // Random commands against the model.
    for (int i = 0; i < 60; i++) begin
      int unsigned sel;
      logic [7:0] rop;
      sel = $urandom_range(0, 9);
      rop = (sel < 7) ? 8'(sel) : 8'($urandom);
      do_cmd(rop, 8'($urandom_range(0, 7)), 8'($urandom), r);
    end

    // Reset while an ADD is waiting on memory.
    cmd_valid = 1'b1;
    opcode    = 8'd3;
    address   = 8'd2;
    chk("pre_reset_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("in_mem_rd", 32'(mem_read), 32'd1);
    ac_before = ac;
    #2 reset = 1'b0;
    #1;
    chk("reset_drop_strobes", 32'({mem_read, mem_write, load_ac, add_enable, sub_enable,
                                   load_mq, busy, done}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ac_kept", 32'(ac), 32'(ac_before));
    reset = 1'b1;
    @(posedge clk); #1;
    ref_cnt = 16'd0;
    chk("reset_release_ready", 32'(cmd_ready), 32'd1);
    chk("reset_release_cnt", 32'(retired_cnt), 32'd0);
    do_cmd(8'd1, 8'd2, 8'd0, r);

    // cmd_valid held high: NOPs accepted only from IDLE.
    period  = 3;
    acc     = 0;
    dn      = 0;
    exp_acc = 0;
    exp_dn  = 0;
    cmd_valid = 1'b1;
    opcode    = 8'd0;
    for (int k = 0; k < 20; k++) begin
      if (cmd_ready) acc++;
      if (done) dn++;
      if (k % period == 0) exp_acc++;
      if (k % period == period - 1) exp_dn++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("held_accepts", 32'(acc), 32'(exp_acc));
    chk("held_dones", 32'(dn), 32'(exp_dn));
    g = 0;
    while (busy && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    if (busy) fail_now("held_drain");
    ref_cnt = ref_cnt + 16'(exp_acc);
    chk("held_cnt", 32'(retired_cnt), 32'(ref_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
